// File: rtl/clock_div_pkg.sv
// Shared types and helpers for the programmable clock-enable scheduler.
package clock_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned CLK_HZ = 100_000_000;

    // Half-period divisor that yields a square wave of the requested frequency.
    function automatic logic [31:0] hz_to_div(input logic [31:0] hz);
        return 32'(CLK_HZ / (32'd2 * hz));
    endfunction

endpackage

// File: rtl/div_counter.sv
// Free-running divider counter with terminal-count flag and synchronous clear.
module div_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic             tc_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_c = (cnt_q == div - CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_div_controller.sv
// Configurable start/stop clock-enable scheduler: periodic or one-shot tick plus a
// toggling clk_out, configured through a valid/ready handshake.
module clock_div_controller
    import clock_div_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 50_000_000
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             clk_out,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             oneshot_q, oneshot_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cfg_acc;
    logic             tc_c;
    logic             cnt_clr;
    logic             cnt_en;

    assign cfg_ready = (state_q != RUN);
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign cnt_en    = (state_q == RUN);
    assign cnt_clr   = stop || (state_q != RUN);

    div_counter #(
        .CNT_W (CNT_W)
    ) u_div_counter (
        .clk   (clk_in),
        .rst_n (reset_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .div   (div_q),
        .tc_c  (tc_c)
    );

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        oneshot_d = oneshot_q;
        tick_d    = 1'b0;
        clk_out_d = clk_out_q;

        // A zero divisor is clamped to 1 so the terminal compare never underflows.
        if (cfg_acc) begin
            div_d     = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
            oneshot_d = cfg_oneshot;
        end

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d   = IDLE;
                    clk_out_d = 1'b0;
                end else if (tc_c) begin
                    tick_d    = 1'b1;
                    clk_out_d = !clk_out_q;
                    if (oneshot_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end else if (cfg_acc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            div_q     <= CNT_W'(DEFAULT_DIV);
            oneshot_q <= 1'b0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            oneshot_q <= oneshot_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_out_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_clock_div_controller.sv
// Directed bench for clock_div_controller: elapsed-time reference model checked every
// cycle, plus literal expectations for tick timing, clk_out pattern and handshake.
module tb_clock_div_controller;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned DEF_DIV = 10;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic             clk_in = 1'b0;
    logic             reset_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_oneshot;
    logic             start;
    logic             stop;
    logic             tick;
    logic             clk_out;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    clock_div_controller #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_div     (cfg_div),
        .cfg_oneshot (cfg_oneshot),
        .start       (start),
        .stop        (stop),
        .tick        (tick),
        .clk_out     (clk_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk_in = ~clk_in;

    // Reference: ticks fall on every multiple of div cycles elapsed since start;
    // clk_out is the parity of the tick count since the run began.
    int              m_mode = M_IDLE;
    longint unsigned m_div  = 64'(DEF_DIV);
    longint unsigned m_el   = 0;
    bit              m_os   = 1'b0;
    bit              m_tick = 1'b0;
    bit              m_clk  = 1'b0;
    bit              m_base = 1'b0;

    initial begin : model
        longint unsigned nd;
        bit              nos;
        bit              acc;
        forever begin
            @(posedge clk_in or negedge reset_n);
            if (!reset_n) begin
                m_mode = M_IDLE; m_div = 64'(DEF_DIV); m_os = 1'b0;
                m_el = 0; m_tick = 1'b0; m_clk = 1'b0; m_base = 1'b0;
            end else begin
                acc = cfg_valid && (m_mode != M_RUN);
                nd  = m_div;
                nos = m_os;
                if (acc) begin
                    nd  = (cfg_div == '0) ? 64'd1 : 64'(cfg_div);
                    nos = cfg_oneshot;
                end
                m_tick = 1'b0;
                if (m_mode == M_IDLE) begin
                    if (start && !stop) begin
                        m_mode = M_RUN; m_el = 0; m_base = m_clk;
                    end
                end else if (m_mode == M_RUN) begin
                    if (stop) begin
                        m_mode = M_IDLE; m_clk = 1'b0;
                    end else begin
                        m_el = m_el + 1;
                        if (m_el % m_div == 0) begin
                            m_tick = 1'b1;
                            m_clk  = m_base ^ ((m_el / m_div) % 64'd2 == 64'd1);
                            if (m_os) m_mode = M_DONE;
                        end
                    end
                end else begin
                    if (stop) m_mode = M_IDLE;
                    else if (start) begin
                        m_mode = M_RUN; m_el = 0; m_base = m_clk;
                    end else if (acc) m_mode = M_IDLE;
                end
                m_div = nd;
                m_os  = nos;
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        chk("model_tick",      tick,      m_tick);
        chk("model_clk_out",   clk_out,   m_clk);
        chk("model_busy",      busy,      m_mode == M_RUN);
        chk("model_done",      done,      m_mode == M_DONE);
        chk("model_cfg_ready", cfg_ready, m_mode != M_RUN);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        compare_outputs();
    endtask

    task automatic do_cfg(input logic [CNT_W-1:0] d, input logic os);
        cfg_valid = 1'b1; cfg_div = d; cfg_oneshot = os;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    logic [15:0] tpat;
    logic [15:0] cpat;

    initial begin
        reset_n = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_oneshot = 1'b0;
        start = 1'b0; stop = 1'b0;
        repeat (3) step();
        chk("rst_tick", tick, 1'b0);
        chk("rst_clk_out", clk_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cfg_ready", cfg_ready, 1'b1);
        reset_n = 1'b1;
        step();

        // Default divisor after reset
        do_start();
        chk("def_busy", busy, 1'b1);
        chk("def_cfg_ready", cfg_ready, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("def_tick", tick, k == 10);
            if (k >= 10) chk("def_clk_out", clk_out, 1'b1);
        end
        do_stop();
        chk("def_stop_clk_out", clk_out, 1'b0);
        chk("def_stop_busy", busy, 1'b0);

        // Periodic div=4, with a config request held throughout the run
        do_cfg(32'd4, 1'b0);
        do_start();
        cfg_valid = 1'b1; cfg_div = 32'd2; cfg_oneshot = 1'b0;
        tpat = 16'b0000_1000_1000_1000;
        cpat = 16'b0000_1111_0000_1111;
        chk("per_clk_k0", clk_out, cpat[15]);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("per_tick", tick, tpat[15-k]);
            chk("per_clk_out", clk_out, cpat[15-k]);
            chk("per_cfg_ready", cfg_ready, 1'b0);
        end
        do_stop();
        chk("per_stop_tc_tick", tick, 1'b0);
        chk("per_stop_ready", cfg_ready, 1'b1);
        step();
        cfg_valid = 1'b0;
        do_start();
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("held_cfg_tick", tick, (k == 2) || (k == 4));
        end
        do_stop();

        // One-shot div=3
        do_cfg(32'd3, 1'b1);
        do_start();
        for (int k = 1; k <= 23; k++) begin
            step();
            chk("os_tick", tick, k == 3);
            chk("os_done", done, k >= 3);
            chk("os_busy", busy, k < 3);
            if (k >= 3) chk("os_clk_hold", clk_out, 1'b1);
        end
        do_stop();
        chk("os_stop_done", done, 1'b0);
        chk("os_stop_ready", cfg_ready, 1'b1);

        // Stop on the terminal-count edge, div=5
        do_cfg(32'd5, 1'b0);
        do_start();
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("tc_pre_tick", tick, 1'b0);
        end
        do_stop();
        chk("tc_stop_tick", tick, 1'b0);
        chk("tc_stop_clk_out", clk_out, 1'b0);
        chk("tc_stop_busy", busy, 1'b0);
        chk("tc_stop_ready", cfg_ready, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("tc_idle_tick", tick, 1'b0);
        end

        // cfg_div = 0 behaves as 1
        do_cfg(32'd0, 1'b0);
        do_start();
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("div0_tick", tick, 1'b1);
            chk("div0_clk_out", clk_out, (k % 2) == 1);
        end
        do_stop();

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", busy, 1'b0);
        step();
        chk("ss_busy2", busy, 1'b0);
        chk("ss_tick", tick, 1'b0);

        // Asynchronous reset mid-run
        do_cfg(32'd3, 1'b0);
        do_start();
        for (int k = 1; k <= 3; k++) step();
        chk("ar_pre_tick", tick, 1'b1);
        chk("ar_pre_clk_out", clk_out, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_tick", tick, 1'b0);
        chk("ar_clk_out", clk_out, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_done", done, 1'b0);
        chk("ar_cfg_ready", cfg_ready, 1'b1);
        compare_outputs();
        @(posedge clk_in);
        #1;
        reset_n = 1'b1;
        step();
        do_start();
        for (int k = 1; k <= 11; k++) begin
            step();
            chk("ar_def_tick", tick, k == 10);
        end
        do_stop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
